wf_gather_tracker: RTL and testbench

- Per-warp gather-completion tracker that drives the 8x4 gather-count RAM (1W/1R, registered read address, read data valid the cycle after R0_en).
- Warp dispatch allocates a gather with an expected beat count. Returning sub-responses increment the warp's count via a 2-stage read-modify-write.
- When the count reaches the expected value, the warp ID is pushed into a 2-entry done queue for the writeback stage.

---
 rtl/wf_gather_tracker.sv | 160 ++++++++++++++++
 tb/tb_wf_gather_tracker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wf_gather_tracker.sv
// ---------------------------------------------------------------------------
// wf_gather_tracker
//
// Tracks outstanding gathers per warp. A dispatch allocates a warp with an
// expected number of response beats; each returning beat bumps the warp's
// count held in an external 1W/1R count RAM through a two-stage
// read-modify-write. When the count reaches the expected value the warp ID is
// pushed into a 2-entry done queue for the writeback stage.
//
// Handshakes: every channel is valid/ready. A transfer happens in a cycle
// where both valid and ready are high. Ready never depends on the same
// channel's valid. A source may hold or drop valid freely while ready is low.
//
// Ports:
//   clock, reset           clock, asynchronous active-low reset
//   alloc_valid/ready      allocation channel; alloc_wid, alloc_num payload
//   rsp_valid/ready        response-beat channel; rsp_wid payload
//   done_valid/ready       completion channel; done_wid payload (queue head)
//   busy                   registered per-warp pending vector
//   err                    sticky protocol error
//   cnt_W0_*               count RAM write port
//   cnt_R0_en/addr         count RAM read request
//   cnt_R0_data            count RAM read data, the cycle after cnt_R0_en
// ---------------------------------------------------------------------------
module wf_gather_tracker #(
  parameter int NUM_WARP = 8,
  parameter int WID_W    = 3,
  parameter int CNT_W    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                alloc_valid,
  output logic                alloc_ready,
  input  logic [WID_W-1:0]    alloc_wid,
  input  logic [CNT_W-1:0]    alloc_num,
  input  logic                rsp_valid,
  output logic                rsp_ready,
  input  logic [WID_W-1:0]    rsp_wid,
  output logic                done_valid,
  input  logic                done_ready,
  output logic [WID_W-1:0]    done_wid,
  output logic [NUM_WARP-1:0] busy,
  output logic                err,
  output logic                cnt_W0_en,
  output logic [WID_W-1:0]    cnt_W0_addr,
  output logic [CNT_W-1:0]    cnt_W0_data,
  output logic                cnt_R0_en,
  output logic [WID_W-1:0]    cnt_R0_addr,
  input  logic [CNT_W-1:0]    cnt_R0_data
);

  // Architectural state
  logic [NUM_WARP-1:0] pending;
  logic [CNT_W-1:0]    expected [NUM_WARP];
  logic                s1_valid;
  logic [WID_W-1:0]    s1_wid;
  logic [WID_W-1:0]    dq_mem [2];
  logic                dq_wr_ptr;
  logic                dq_rd_ptr;
  logic [1:0]          dq_cnt;
  logic                err_q;

  // Combinational helpers
  logic [CNT_W-1:0]    s1_new;
  logic                s1_done;
  logic                s1_wrap;
  logic [NUM_WARP-1:0] clr_vec;
  logic [NUM_WARP-1:0] set_vec;
  logic [NUM_WARP-1:0] pend_eff;
  logic                alloc_fire;
  logic                rsp_fire;
  logic                rsp_hit;
  logic                rsp_miss;
  logic                dq_push;
  logic                dq_pop;

  // Stage 1: the read data returned this cycle belongs to s1_wid.
  // A zero expected count marks a mis-allocated warp that must never retire,
  // even when its count wraps back to zero.
  always_comb begin
    s1_new  = cnt_R0_data + CNT_W'(1);
    s1_done = s1_valid && (s1_new == expected[s1_wid]) &&
              (expected[s1_wid] != '0);
    s1_wrap = s1_valid && (s1_new == '0);
    clr_vec = s1_done ? (NUM_WARP'(1) << s1_wid) : '0;
    // Stage 0 judges beats against the pending set after this cycle's retire.
    pend_eff = pending & ~clr_vec;
  end

  // Ready terms are forced low while reset is asserted so nothing upstream
  // sees a transfer during reset.
  always_comb begin
    alloc_ready = reset && !pending[alloc_wid] && !s1_valid;
    // Reserve a queue slot for the beat currently in stage 1 so the done
    // queue can never overflow.
    rsp_ready   = reset && (({1'b0, dq_cnt} + {2'b00, s1_valid}) < 3'd2);
    alloc_fire  = alloc_valid && alloc_ready;
    rsp_fire    = rsp_valid && rsp_ready;
    rsp_hit     = rsp_fire && pend_eff[rsp_wid];
    rsp_miss    = rsp_fire && !pend_eff[rsp_wid];
    set_vec     = alloc_fire ? (NUM_WARP'(1) << alloc_wid) : '0;
    dq_push     = s1_done;
    dq_pop      = done_valid && done_ready;
  end

  // Count RAM ports. Stage 1 and allocation never write in the same cycle
  // because allocation is held off while stage 1 is occupied.
  always_comb begin
    cnt_W0_en   = 1'b0;
    cnt_W0_addr = '0;
    cnt_W0_data = '0;
    if (s1_valid) begin
      cnt_W0_en   = reset;
      cnt_W0_addr = s1_wid;
      cnt_W0_data = s1_new;
    end else if (alloc_fire) begin
      cnt_W0_en   = 1'b1;
      cnt_W0_addr = alloc_wid;
      cnt_W0_data = '0;
    end
    cnt_R0_en   = rsp_hit;
    cnt_R0_addr = rsp_wid;
  end

  always_comb begin
    done_valid = (dq_cnt != 2'd0);
    done_wid   = dq_mem[dq_rd_ptr];
    busy       = pending;
    err        = err_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending   <= '0;
      for (int i = 0; i < NUM_WARP; i++) expected[i] <= '0;
      s1_valid  <= 1'b0;
      s1_wid    <= '0;
      dq_mem[0] <= '0;
      dq_mem[1] <= '0;
      dq_wr_ptr <= 1'b0;
      dq_rd_ptr <= 1'b0;
      dq_cnt    <= 2'd0;
      err_q     <= 1'b0;
    end else begin
      pending  <= pend_eff | set_vec;
      if (alloc_fire) expected[alloc_wid] <= alloc_num;
      s1_valid <= rsp_hit;
      if (rsp_hit) s1_wid <= rsp_wid;
      if (dq_push) begin
        dq_mem[dq_wr_ptr] <= s1_wid;
        dq_wr_ptr         <= ~dq_wr_ptr;
      end
      if (dq_pop) dq_rd_ptr <= ~dq_rd_ptr;
      dq_cnt <= dq_cnt + {1'b0, dq_push} - {1'b0, dq_pop};
      if (rsp_miss || s1_wrap || (alloc_fire && (alloc_num == '0)))
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wf_gather_tracker.sv
module tb_wf_gather_tracker;

  localparam int NW = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          alloc_valid = 1'b0;
  logic          alloc_ready;
  logic [2:0]    alloc_wid = '0;
  logic [3:0]    alloc_num = '0;
  logic          rsp_valid = 1'b0;
  logic          rsp_ready;
  logic [2:0]    rsp_wid = '0;
  logic          done_valid;
  logic          done_ready = 1'b0;
  logic [2:0]    done_wid;
  logic [NW-1:0] busy;
  logic          err;
  logic          cnt_W0_en;
  logic [2:0]    cnt_W0_addr;
  logic [3:0]    cnt_W0_data;
  logic          cnt_R0_en;
  logic [2:0]    cnt_R0_addr;
  logic [3:0]    cnt_R0_data;

  wf_gather_tracker #(.NUM_WARP(8), .WID_W(3), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_wid(alloc_wid), .alloc_num(alloc_num),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wid(rsp_wid),
    .done_valid(done_valid), .done_ready(done_ready), .done_wid(done_wid),
    .busy(busy), .err(err),
    .cnt_W0_en(cnt_W0_en), .cnt_W0_addr(cnt_W0_addr), .cnt_W0_data(cnt_W0_data),
    .cnt_R0_en(cnt_R0_en), .cnt_R0_addr(cnt_R0_addr), .cnt_R0_data(cnt_R0_data)
  );

  // Count RAM: registered read, a write at an edge is visible to a read
  // issued at that same edge.
  logic [3:0] ram [NW];
  always @(posedge clock) begin
    if (cnt_R0_en)
      cnt_R0_data <= (cnt_W0_en && cnt_W0_addr == cnt_R0_addr) ? cnt_W0_data : ram[cnt_R0_addr];
    if (cnt_W0_en) ram[cnt_W0_addr] <= cnt_W0_data;
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: abstract per-warp counters and a completion queue.
  int         m_cnt [NW];
  int         m_exp [NW];
  bit         m_pend [NW];
  bit         m_err;
  bit         m_inflight;
  int         m_inflight_wid;
  logic [2:0] exp_q [$];

  function automatic void model_reset();
    for (int i = 0; i < NW; i++) begin
      m_cnt[i] = 0; m_exp[i] = 0; m_pend[i] = 0;
    end
    m_err = 0; m_inflight = 0; m_inflight_wid = 0;
    exp_q.delete();
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit av, input logic [2:0] aw, input logic [3:0] an,
                      input bit rv, input logic [2:0] rw, input bit dr);
    int  new_c;
    bit  compl;
    bit  pe [NW];
    bit  e_ar, e_rr, a_fire, r_fire, r_hit;
    logic [NW-1:0] e_busy;
    @(negedge clock);
    alloc_valid = av; alloc_wid = aw; alloc_num = an;
    rsp_valid = rv; rsp_wid = rw; done_ready = dr;
    #1;
    new_c = 0; compl = 0;
    if (m_inflight) begin
      new_c = (m_cnt[m_inflight_wid] + 1) % 16;
      compl = (new_c == m_exp[m_inflight_wid]) && (m_exp[m_inflight_wid] != 0);
    end
    for (int i = 0; i < NW; i++) begin
      pe[i] = m_pend[i];
      e_busy[i] = m_pend[i];
    end
    if (compl) pe[m_inflight_wid] = 0;
    e_ar   = !m_pend[aw] && !m_inflight;
    e_rr   = (exp_q.size() + int'(m_inflight)) < 2;
    a_fire = av && e_ar;
    r_fire = rv && e_rr;
    r_hit  = r_fire && pe[rw];

    check("alloc_ready", alloc_ready, e_ar);
    check("rsp_ready", rsp_ready, e_rr);
    check("done_valid", done_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("done_wid", done_wid, exp_q[0]);
    check("busy", busy, e_busy);
    check("err", err, m_err);
    check("w0_en", cnt_W0_en, m_inflight || a_fire);
    if (m_inflight) begin
      check("w0_addr_rmw", cnt_W0_addr, m_inflight_wid);
      check("w0_data_rmw", cnt_W0_data, new_c);
    end else if (a_fire) begin
      check("w0_addr_alloc", cnt_W0_addr, aw);
      check("w0_data_alloc", cnt_W0_data, 0);
    end
    check("r0_en", cnt_R0_en, r_hit);
    if (r_hit) check("r0_addr", cnt_R0_addr, rw);

    // advance model to the state after this clock edge
    if (dr && exp_q.size() != 0) void'(exp_q.pop_front());
    if (m_inflight) begin
      m_cnt[m_inflight_wid] = new_c;
      if (new_c == 0) m_err = 1;
      if (compl) begin
        exp_q.push_back(3'(m_inflight_wid));
        m_pend[m_inflight_wid] = 0;
      end
    end
    if (a_fire) begin
      m_pend[aw] = 1; m_exp[aw] = int'(an); m_cnt[aw] = 0;
      if (an == 0) m_err = 1;
    end
    if (r_fire && !r_hit) m_err = 1;
    m_inflight = r_hit;
    m_inflight_wid = int'(rw);
  endtask

  task automatic idle(input int n, input bit dr);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, dr);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    alloc_valid = 0; rsp_valid = 0; done_ready = 0;
    #1;
    check("rst_alloc_ready", alloc_ready, 0);
    check("rst_rsp_ready", rsp_ready, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_w0_en", cnt_W0_en, 0);
    check("rst_r0_en", cnt_R0_en, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pick;
    int plist [$];
    for (int i = 0; i < NW; i++) ram[i] = 4'($urandom_range(0, 15));
    model_reset();
    do_reset();

    // Three back-to-back beats to warp 2, then drain.
    step(1, 2, 3, 0, 0, 0);
    step(0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 1, 2, 0);
    idle(3, 0);
    idle(2, 1);

    // Interleave warps 0 and 5 with the queue stalled, then drain.
    step(1, 0, 1, 0, 0, 0);
    step(1, 5, 2, 0, 0, 0);
    step(0, 0, 0, 1, 5, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 5, 0);
    step(0, 0, 0, 1, 5, 0);   // queue full: beat must not be taken
    idle(2, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    idle(1, 1);

    // Beat for an unallocated warp.
    step(0, 0, 0, 1, 4, 1);
    idle(3, 1);

    // Allocation collides with an occupied stage 1.
    do_reset();
    step(1, 3, 2, 0, 0, 1);
    step(0, 0, 0, 1, 3, 1);
    step(1, 1, 4, 0, 0, 1);
    step(1, 1, 4, 0, 0, 1);
    idle(2, 1);

    // Re-allocation right after completion.
    do_reset();
    step(1, 3, 1, 0, 0, 1);
    step(0, 0, 0, 1, 3, 0);
    idle(1, 0);
    step(1, 3, 2, 0, 0, 1);
    step(0, 0, 0, 1, 3, 0);
    step(0, 0, 0, 1, 3, 0);
    idle(3, 1);

    // Reset with a beat in stage 1 and one queued completion.
    do_reset();
    step(1, 6, 1, 0, 0, 0);
    step(1, 7, 2, 0, 0, 0);
    step(0, 0, 0, 1, 6, 0);
    step(0, 0, 0, 1, 7, 0);
    do_reset();
    idle(2, 1);

    // Randomized traffic, biased toward beats for pending warps.
    for (int chunk = 0; chunk < 4; chunk++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        bit av, rv, dr;
        logic [2:0] aw, rw;
        logic [3:0] an;
        av = ($urandom_range(0, 2) == 0);
        aw = 3'($urandom_range(0, 7));
        an = ($urandom_range(0, 63) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
        rv = ($urandom_range(0, 3) != 0);
        plist.delete();
        for (int i = 0; i < NW; i++) if (m_pend[i]) plist.push_back(i);
        if (plist.size() != 0 && $urandom_range(0, 9) != 0) begin
          pick = plist[$urandom_range(0, plist.size() - 1)];
          rw = 3'(pick);
        end else begin
          rw = 3'($urandom_range(0, 7));
        end
        dr = ($urandom_range(0, 1) == 1);
        step(av, aw, an, rv, rw, dr);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
